// File: rtl/inst_loop_seq.sv
// -----------------------------------------------------------------------------
// inst_loop_seq
//   Instruction sequencer downstream of the CSR block. After a start pulse it
//   walks the instruction-memory program counter from 0, applying up to three
//   nested hardware loops (loop 1 innermost). Each PC is offered to the
//   fetch/decode stage over a valid/ready handshake, and the PC only advances
//   when a handshake takes place.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 start pulse (ignored while busy or in write mode)
//   clr_i                   synchronous abort pulse, returns to idle
//   write_mode_i            instruction write mode; blocks start_i
//   loop_mode_i             number of active nested loops (0..3)
//   jump_addrN_i            loop N jump target
//   end_addrN_i             loop N last instruction
//   countN_i                loop N iteration count (0 behaves as 1)
//   pc_o, pc_valid_o        registered program counter and its valid flag
//   pc_ready_i              consumer accepts pc_o
//   busy_o                  sequencer running
//   done_o                  one-cycle pulse on the final handshake
// -----------------------------------------------------------------------------
module inst_loop_seq #(
  parameter int InstMemDepth     = 32,
  parameter int InstMemAddrWidth = $clog2(InstMemDepth)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        clr_i,
  input  logic                        write_mode_i,
  input  logic [1:0]                  loop_mode_i,
  input  logic [InstMemAddrWidth-1:0] jump_addr1_i,
  input  logic [InstMemAddrWidth-1:0] jump_addr2_i,
  input  logic [InstMemAddrWidth-1:0] jump_addr3_i,
  input  logic [InstMemAddrWidth-1:0] end_addr1_i,
  input  logic [InstMemAddrWidth-1:0] end_addr2_i,
  input  logic [InstMemAddrWidth-1:0] end_addr3_i,
  input  logic [InstMemAddrWidth-1:0] count1_i,
  input  logic [InstMemAddrWidth-1:0] count2_i,
  input  logic [InstMemAddrWidth-1:0] count3_i,
  output logic [InstMemAddrWidth-1:0] pc_o,
  output logic                        pc_valid_o,
  input  logic                        pc_ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int AW = InstMemAddrWidth;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [AW-1:0] PcLast = AW'(InstMemDepth - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic [1:0]    mode_q, mode_d;

  // Index 0 holds loop 1 (innermost), index 2 holds loop 3 (outermost).
  logic [AW-1:0] jump_q [3];
  logic [AW-1:0] jump_d [3];
  logic [AW-1:0] end_q  [3];
  logic [AW-1:0] end_d  [3];
  logic [AW-1:0] cnt_q  [3];
  logic [AW-1:0] cnt_d  [3];
  logic [AW-1:0] ctr_q  [3];
  logic [AW-1:0] ctr_d  [3];

  logic          hs;
  logic          last;
  logic          taken;
  logic          done;
  logic [2:0]    match;
  logic [2:0]    can_jump;
  logic [AW-1:0] lim [3];
  logic [AW-1:0] pc_inc;

  always_comb begin
    hs     = valid_q & pc_ready_i;
    pc_inc = (pc_q == PcLast) ? '0 : pc_q + 1'b1;

    // A loop can jump back while its counter is below N-1; a count of zero
    // gets the same limit as a count of one.
    for (int unsigned i = 0; i < 3; i++) begin
      lim[i]      = (cnt_q[i] == '0) ? '0 : cnt_q[i] - 1'b1;
      match[i]    = (2'(i) < mode_q) && (pc_q == end_q[i]);
      can_jump[i] = match[i] && (ctr_q[i] < lim[i]);
    end

    // Program ends when the outermost active loop is passed exhausted and no
    // inner loop takes a jump on the same address.
    case (mode_q)
      2'd0:    last = (pc_q == end_q[0]);
      2'd1:    last = ~|can_jump & match[0];
      2'd2:    last = ~|can_jump & match[1];
      default: last = ~|can_jump & match[2];
    endcase

    done = (state_q == StRun) & hs & last & ~clr_i & ~rst_i;

    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    mode_d  = mode_q;
    taken   = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      jump_d[i] = jump_q[i];
      end_d[i]  = end_q[i];
      cnt_d[i]  = cnt_q[i];
      ctr_d[i]  = ctr_q[i];
    end

    if (clr_i) begin
      state_d = StIdle;
      pc_d    = '0;
      valid_d = 1'b0;
      for (int unsigned i = 0; i < 3; i++) ctr_d[i] = '0;
    end else if (state_q == StIdle) begin
      if (start_i && !write_mode_i) begin
        state_d   = StRun;
        pc_d      = '0;
        valid_d   = 1'b1;
        mode_d    = loop_mode_i;
        jump_d[0] = jump_addr1_i;
        jump_d[1] = jump_addr2_i;
        jump_d[2] = jump_addr3_i;
        end_d[0]  = end_addr1_i;
        end_d[1]  = end_addr2_i;
        end_d[2]  = end_addr3_i;
        cnt_d[0]  = count1_i;
        cnt_d[1]  = count2_i;
        cnt_d[2]  = count3_i;
        for (int unsigned i = 0; i < 3; i++) ctr_d[i] = '0;
      end
    end else if (hs) begin
      if (last) begin
        state_d = StIdle;
        pc_d    = '0;
        valid_d = 1'b0;
        for (int unsigned i = 0; i < 3; i++) ctr_d[i] = '0;
      end else begin
        // Ascending scan: the first loop able to jump wins; matching loops
        // below it are exhausted and restart, loops above it are untouched.
        for (int unsigned i = 0; i < 3; i++) begin
          if (!taken) begin
            if (can_jump[i]) begin
              taken    = 1'b1;
              pc_d     = jump_q[i];
              ctr_d[i] = ctr_q[i] + 1'b1;
            end else if (match[i]) begin
              ctr_d[i] = '0;
            end
          end
        end
        if (!taken) pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      valid_q <= 1'b0;
      mode_q  <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        jump_q[i] <= '0;
        end_q[i]  <= '0;
        cnt_q[i]  <= '0;
        ctr_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      for (int unsigned i = 0; i < 3; i++) begin
        jump_q[i] <= jump_d[i];
        end_q[i]  <= end_d[i];
        cnt_q[i]  <= cnt_d[i];
        ctr_q[i]  <= ctr_d[i];
      end
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = valid_q;
  assign busy_o     = (state_q == StRun);
  assign done_o     = done;

endmodule

// File: tb/tb_inst_loop_seq.sv
module tb_inst_loop_seq;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          write_mode_i = 1'b0;
  logic [1:0]    loop_mode_i = '0;
  logic [AW-1:0] jump_addr1_i = '0, jump_addr2_i = '0, jump_addr3_i = '0;
  logic [AW-1:0] end_addr1_i = '0, end_addr2_i = '0, end_addr3_i = '0;
  logic [AW-1:0] count1_i = '0, count2_i = '0, count3_i = '0;
  logic [AW-1:0] pc_o;
  logic          pc_valid_o;
  logic          pc_ready_i = 1'b1;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int failures = 0;
  int q[$];

  int e_m0[4]   = '{0, 1, 2, 3};
  int e_m1[11]  = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4};
  int e_m2[12]  = '{0, 1, 2, 1, 2, 3, 0, 1, 2, 1, 2, 3};
  int e_c0[2]   = '{0, 1};
  int e_six[6]  = '{0, 1, 2, 3, 4, 5};

  inst_loop_seq #(.InstMemDepth(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .clr_i        (clr_i),
    .write_mode_i (write_mode_i),
    .loop_mode_i  (loop_mode_i),
    .jump_addr1_i (jump_addr1_i),
    .jump_addr2_i (jump_addr2_i),
    .jump_addr3_i (jump_addr3_i),
    .end_addr1_i  (end_addr1_i),
    .end_addr2_i  (end_addr2_i),
    .end_addr3_i  (end_addr3_i),
    .count1_i     (count1_i),
    .count2_i     (count2_i),
    .count3_i     (count3_i),
    .pc_o         (pc_o),
    .pc_valid_o   (pc_valid_o),
    .pc_ready_i   (pc_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int mode, input int j1, input int e1, input int c1,
                     input int j2, input int e2, input int c2);
    loop_mode_i  = 2'(mode);
    jump_addr1_i = AW'(j1);
    end_addr1_i  = AW'(e1);
    count1_i     = AW'(c1);
    jump_addr2_i = AW'(j2);
    end_addr2_i  = AW'(e2);
    count2_i     = AW'(c2);
    jump_addr3_i = '0;
    end_addr3_i  = '0;
    count3_i     = '0;
  endtask

  // Leaves the bench at the negedge where the first PC is presented.
  task automatic start_prog();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_valid"}, int'(pc_valid_o), 0);
    chk({tag, "_pc"}, int'(pc_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
  endtask

  // Consumes handshakes against the scoreboard until it is empty.
  task automatic drain(input int stall_pc, input int stall_len, input bit mid_start);
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 0;
    bit fin = 0;
    int exp;
    while (!fin && cyc < 300) begin
      if (mid_start) begin
        if (cyc == 2) begin
          start_i     = 1'b1;
          loop_mode_i = 2'd1;
          end_addr1_i = 5'd1;
          jump_addr1_i = 5'd0;
          count1_i    = 5'd3;
        end else if (cyc == 3) begin
          start_i = 1'b0;
        end
      end
      if (stall_left > 0) begin
        pc_ready_i = 1'b0;
        stall_left--;
      end else if (stall_pc >= 0 && !stalled && pc_valid_o && int'(pc_o) == stall_pc) begin
        stalled    = 1'b1;
        pc_ready_i = 1'b0;
        stall_left = stall_len - 1;
      end else begin
        pc_ready_i = 1'b1;
      end
      #1;
      if (!pc_ready_i) begin
        chk("stall_pc", int'(pc_o), stall_pc);
        chk("stall_valid", int'(pc_valid_o), 1);
        chk("stall_done", int'(done_o), 0);
      end else if (pc_valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", int'(pc_valid_o), 0);
          fin = 1'b1;
        end else begin
          exp = q.pop_front();
          chk("pc", int'(pc_o), exp);
          chk("done", int'(done_o), (q.size() == 0) ? 1 : 0);
          if (q.size() == 0) fin = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("drain_complete", int'(fin), 1);
    pc_ready_i = 1'b1;
    #1;
    check_idle("after_done");
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_idle("reset");

    // Mode 0, straight line to end1=3
    cfg(0, 0, 3, 0, 0, 0, 0);
    foreach (e_m0[i]) q.push_back(e_m0[i]);
    start_prog();
    drain(-1, 0, 1'b0);

    // Mode 1, single loop 2..4 three times
    cfg(1, 2, 4, 3, 0, 0, 0);
    foreach (e_m1[i]) q.push_back(e_m1[i]);
    start_prog();
    drain(-1, 0, 1'b0);

    // Mode 2, two nested loops
    cfg(2, 1, 2, 2, 0, 3, 2);
    foreach (e_m2[i]) q.push_back(e_m2[i]);
    start_prog();
    drain(-1, 0, 1'b0);

    // Mode 1, count 0 behaves as 1
    cfg(1, 0, 1, 0, 0, 0, 0);
    foreach (e_c0[i]) q.push_back(e_c0[i]);
    start_prog();
    drain(-1, 0, 1'b0);

    // Mode 1 with a 5-cycle back-pressure stall at pc=3
    cfg(1, 2, 4, 3, 0, 0, 0);
    foreach (e_m1[i]) q.push_back(e_m1[i]);
    start_prog();
    drain(3, 5, 1'b0);

    // Clear at pc=2, then a clean restart
    cfg(1, 2, 4, 3, 0, 0, 0);
    start_prog();
    pc_ready_i = 1'b1;
    #1;
    chk("clr_pc0", int'(pc_o), 0);
    @(negedge clk);
    #1;
    chk("clr_pc1", int'(pc_o), 1);
    @(negedge clk);
    clr_i = 1'b1;
    #1;
    chk("clr_pc2", int'(pc_o), 2);
    chk("clr_no_done", int'(done_o), 0);
    @(negedge clk);
    clr_i = 1'b0;
    #1;
    check_idle("after_clr");
    foreach (e_m1[i]) q.push_back(e_m1[i]);
    start_prog();
    drain(-1, 0, 1'b0);

    // start_i while busy is ignored, as are input changes during the run
    cfg(0, 0, 5, 0, 0, 0, 0);
    foreach (e_six[i]) q.push_back(e_six[i]);
    start_prog();
    drain(-1, 0, 1'b1);

    // start_i with write mode high stays idle
    cfg(0, 0, 3, 0, 0, 0, 0);
    write_mode_i = 1'b1;
    start_prog();
    #1;
    check_idle("write_mode");
    @(negedge clk);
    chk("write_mode_busy2", int'(busy_o), 0);
    write_mode_i = 1'b0;

    // Zero-length program: only pc 0, then done
    cfg(0, 0, 0, 0, 0, 0, 0);
    q.push_back(0);
    start_prog();
    drain(-1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
